uart_dump_ctrl: RTL and testbench
=================================

Name: uart_dump_ctrl

Overview:
- Command sequencer sitting between the UART link (receiver byte output, transmitter byte input) and the logic-analyzer capture memory.
- Decodes single-byte host commands: arm, status and dump.
- Sequences the transmitter byte by byte using its busy handshake.
- Streams the capture buffer as a framed packet: header, DEPTH data bytes, 8-bit checksum.

Parameters:
ADDR_W, 10, capture memory address width
DEPTH, 1024, bytes per dump; 1 <= DEPTH <= 2**ADDR_W
HDR_BYTE, 8'hA5, frame header byte

Ports:
input_clk  in  1  system clock
reset  in  1  asynchronous active-low reset
rx_data  in  8  byte from the UART receiver; stable while rx_rdy is high
rx_rdy  in  1  receiver data-ready level, baud domain, async to input_clk
tx_busy  in  1  transmitter busy level, async to input_clk
tx_data  out  8  byte to the transmitter
tx_start  out  1  transmit request level; transmitter latches on its rising edge
mem_addr  out  ADDR_W  capture memory read address
mem_rdata  in  8  capture memory read data, valid 1 cycle after mem_addr
capture_done  in  1  capture buffer full and valid
arm  out  1  one-cycle pulse that re-arms the trigger
dump_active  out  1  high from header load until the checksum byte completes

Behaviour:
- Reset values: tx_data=0, tx_start=0, mem_addr=0, arm=0, dump_active=0, checksum=0, state=IDLE.
- Synchronisers:
  - rx_rdy and tx_busy each pass through a 2-flop synchroniser into input_clk.
  - A command strobe fires on the synchronised rx_rdy rising edge; rx_data is sampled in that cycle.
- Commands, accepted only in IDLE; strobes in any other state are dropped:
  - 0x41 'A': arm=1 for exactly 1 cycle, stay IDLE, no reply.
  - 0x3F '?': send one status byte {6'b0, capture_done, dump_active}.
  - 0x44 'D': if capture_done=1 start a dump; else send NAK 0x15.
  - Any other byte is ignored.
- Byte send sub-sequence (SEND):
  - Drive tx_data, set tx_start=1.
  - WAIT_HI: hold until sync tx_busy=1, then tx_start=0.
  - WAIT_LO: hold until sync tx_busy=0; byte complete.
  - tx_data is held constant from SEND through WAIT_LO.
  - No timeout.
- Dump FSM: IDLE -> HDR -> (SEND/WAIT_HI/WAIT_LO) -> RD -> RD_WAIT -> DATA -> (SEND...) -> RD ... -> CSUM -> (SEND...) -> IDLE.
  - HDR: dump_active=1, checksum=0, mem_addr=0, send HDR_BYTE.
  - RD: present mem_addr. RD_WAIT: 1 cycle memory latency. DATA: capture mem_rdata into tx_data, checksum += mem_rdata (mod 256), send.
  - After each data byte completes: if mem_addr==DEPTH-1 go to CSUM, else mem_addr+1 and go to RD.
  - CSUM: send (~checksum + 1) mod 256, i.e. two's complement, so the sum of data bytes plus the checksum byte is 0 mod 256. The header is excluded from the checksum.
  - dump_active falls in the cycle WAIT_LO completes the checksum byte.
- Abort: a 0x1B strobe during a dump sets an abort flag.
  - The byte in flight completes.
  - Then the controller sends 0x18 instead of continuing and returns to IDLE.
  - No checksum is sent.
- mem_addr wraps nowhere: DEPTH bounds it. DEPTH=1 sends header, 1 byte, checksum.
- capture_done is sampled only at command decode; a deassert mid-dump has no effect.
- Asynchronous reset mid-operation:
  - Immediate return to IDLE, all outputs to reset values.
  - A partially transmitted byte is abandoned; the host discards the frame.
- Latency: strobe to tx_start rise is at most 3 input_clk cycles for status/NAK/header.

Decomposition:
- Package uart_ctrl_pkg: state enum (IDLE, HDR, RD, RD_WAIT, DATA, CSUM, SEND, WAIT_HI, WAIT_LO), command constants CMD_ARM=8'h41, CMD_STATUS=8'h3F, CMD_DUMP=8'h44, CMD_ABORT=8'h1B, NAK=8'h15, ABORT_ACK=8'h18.
- One sub-module, sync_2ff (parametrised width, async active-low reset), instantiated for rx_rdy and tx_busy.
- The send sub-sequence is inline states with a return-state register, not a separate module.

Test Plan:
- Bench model: the UART transmitter asserts busy 3 cycles after tx_start rises and holds it 20 cycles.
- Arm: rx 0x41 -> arm high exactly 1 cycle, no tx_start.
- Status: capture_done=1, rx 0x3F -> single tx byte 0x02.
- NAK: capture_done=0, rx 0x44 -> single tx byte 0x15, dump_active never rises.
- Dump: DEPTH=4, memory {0x01,0x02,0x03,0x04}, rx 0x44 -> tx sequence A5,01,02,03,04,F6.
  - dump_active is high from A5 through F6.
  - Strobes of 0x3F during the dump produce no extra bytes.
- Abort: DEPTH=16, rx 0x1B during the 3rd data byte -> that byte completes, next byte is 0x18, then IDLE. A new 0x3F is answered with 0x00.
- Reset mid-dump: drop reset during WAIT_HI of data byte 2 -> all outputs 0 in the same cycle. After release, rx 0x44 restarts cleanly from header A5 with mem_addr=0.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared state encoding and command byte constants for the UART dump controller.
package uart_ctrl_pkg;
    typedef enum logic [3:0] {
        IDLE, HDR, RD, RD_WAIT, DATA, CSUM, SEND, WAIT_HI, WAIT_LO
    } state_t;
    localparam logic [7:0] CMD_ARM    = 8'h41;
    localparam logic [7:0] CMD_STATUS = 8'h3F;
    localparam logic [7:0] CMD_DUMP   = 8'h44;
    localparam logic [7:0] CMD_ABORT  = 8'h1B;
    localparam logic [7:0] NAK        = 8'h15;
    localparam logic [7:0] ABORT_ACK  = 8'h18;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for slow asynchronous levels.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta, r_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end
    assign o_q = r_sync;
endmodule

// File: rtl/uart_dump_ctrl.sv
// uart_dump_ctrl: decodes host command bytes and streams the capture buffer as a
// framed, checksummed packet through a busy-handshaked UART transmitter.
module uart_dump_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int         ADDR_W   = 10,
    parameter int         DEPTH    = 1024,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic              input_clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              capture_done,
    output logic              arm,
    output logic              dump_active
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state, r_ret;
    logic [7:0]        r_tx_data, r_csum;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_tx_start, r_arm, r_dump_active, r_abort, r_inc, r_rx_rdy_d;
    logic              w_rx_rdy_s, w_tx_busy_s, w_strobe;

    sync_2ff #(.W(1)) u_sync_rx (.clk(input_clk), .rst_n(reset), .i_d(rx_rdy),  .o_q(w_rx_rdy_s));
    sync_2ff #(.W(1)) u_sync_tx (.clk(input_clk), .rst_n(reset), .i_d(tx_busy), .o_q(w_tx_busy_s));

    assign w_strobe = w_rx_rdy_s & ~r_rx_rdy_d;

    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_ret         <= IDLE;
            r_tx_data     <= '0;
            r_csum        <= '0;
            r_mem_addr    <= '0;
            r_tx_start    <= 1'b0;
            r_arm         <= 1'b0;
            r_dump_active <= 1'b0;
            r_abort       <= 1'b0;
            r_inc         <= 1'b0;
            r_rx_rdy_d    <= 1'b0;
        end else begin
            r_rx_rdy_d <= w_rx_rdy_s;
            r_arm      <= 1'b0;
            if (w_strobe && r_dump_active && rx_data == CMD_ABORT)
                r_abort <= 1'b1;
            case (r_state)
                IDLE: if (w_strobe) begin
                    if (rx_data == CMD_ARM)
                        r_arm <= 1'b1;
                    else if (rx_data == CMD_STATUS) begin
                        r_tx_data <= {6'b0, capture_done, r_dump_active};
                        r_ret     <= IDLE;
                        r_state   <= SEND;
                    end else if (rx_data == CMD_DUMP) begin
                        r_tx_data <= NAK;
                        r_ret     <= IDLE;
                        r_state   <= capture_done ? HDR : SEND;
                    end
                end
                HDR: begin
                    r_dump_active <= 1'b1;
                    r_csum        <= '0;
                    r_mem_addr    <= '0;
                    r_tx_data     <= HDR_BYTE;
                    r_ret         <= RD;
                    r_state       <= SEND;
                end
                RD:      r_state <= RD_WAIT;
                RD_WAIT: r_state <= DATA;
                DATA: begin
                    r_tx_data <= mem_rdata;
                    r_csum    <= r_csum + mem_rdata;
                    r_inc     <= r_mem_addr != LAST_ADDR;
                    r_ret     <= (r_mem_addr == LAST_ADDR) ? CSUM : RD;
                    r_state   <= SEND;
                end
                CSUM: begin
                    r_tx_data <= ~r_csum + 8'd1;
                    r_ret     <= IDLE;
                    r_state   <= SEND;
                end
                SEND: begin
                    r_tx_start <= 1'b1;
                    r_state    <= WAIT_HI;
                end
                WAIT_HI: if (w_tx_busy_s) begin
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT_LO;
                end
                WAIT_LO: if (!w_tx_busy_s) begin
                    r_mem_addr <= r_mem_addr + ADDR_W'(r_inc);
                    r_inc      <= 1'b0;
                    // an abort landing on the final byte of a frame has nothing left to cancel
                    if (r_abort && r_ret != IDLE) begin
                        r_abort   <= 1'b0;
                        r_tx_data <= ABORT_ACK;
                        r_ret     <= IDLE;
                        r_state   <= SEND;
                    end else begin
                        r_state <= r_ret;
                        if (r_ret == IDLE) begin
                            r_dump_active <= 1'b0;
                            r_abort       <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign mem_addr    = r_mem_addr;
    assign arm         = r_arm;
    assign dump_active = r_dump_active;
endmodule

// File: tb/tb_uart_dump_ctrl.sv
// tb_uart_dump_ctrl: two controller instances (DEPTH 4 and 16) driven by a shared host,
// each with its own transmitter and capture memory model.
module tb_uart_dump_ctrl;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] cmd;
        logic       cd;
        int         n;
        logic [7:0] b0;
        int         arms;
    } vec_t;

    logic       clk = 0, rst_n = 0, rx_rdy = 0;
    logic [7:0] rx_data = 0;
    int         sel = 0;
    logic       cd4 = 0, cd16 = 0, busy4 = 0, busy16 = 0;
    logic [7:0] txd4, txd16, rd4 = 0, rd16 = 0;
    logic       ts4, ts16, arm4, arm16, da4, da16;
    logic [9:0] addr4, addr16;
    logic [7:0] mem4[4];
    logic [7:0] mem16[16];
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    uart_dump_ctrl #(.ADDR_W(10), .DEPTH(4), .HDR_BYTE(8'hA5)) u_dut4 (
        .input_clk(clk), .reset(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy && sel == 0),
        .tx_busy(busy4), .tx_data(txd4), .tx_start(ts4), .mem_addr(addr4),
        .mem_rdata(rd4), .capture_done(cd4), .arm(arm4), .dump_active(da4));
    uart_dump_ctrl #(.ADDR_W(10), .DEPTH(16), .HDR_BYTE(8'hA5)) u_dut16 (
        .input_clk(clk), .reset(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy && sel == 1),
        .tx_busy(busy16), .tx_data(txd16), .tx_start(ts16), .mem_addr(addr16),
        .mem_rdata(rd16), .capture_done(cd16), .arm(arm16), .dump_active(da16));

    always @(posedge clk) begin
        rd4  <= mem4[addr4[1:0]];
        rd16 <= mem16[addr16[3:0]];
    end

    // transmitter model: busy rises 3 cycles after tx_start rises and holds for 20 cycles
    bq_t        log4, log16;
    logic       dal4[$];
    logic       dal16[$];
    logic       st4_d = 0, st16_d = 0, inb4 = 0, inb16 = 0;
    logic [7:0] held4 = 0, held16 = 0;
    int         t4 = 0, h4 = 0, t16 = 0, h16 = 0;
    int         viol4 = 0, viol16 = 0, armc4 = 0, armc16 = 0, dac16 = 0;

    always @(negedge clk) begin
        if (arm4) armc4++;
        if (ts4 && !st4_d) begin
            log4.push_back(txd4); dal4.push_back(da4);
            held4 = txd4; inb4 = 1; t4 = 3;
        end else if (t4 > 0) begin
            t4--;
            if (t4 == 0) begin busy4 = 1; h4 = 20; end
        end else if (h4 > 0) begin
            h4--;
            if (h4 == 0) begin busy4 = 0; inb4 = 0; end
        end
        if (!rst_n) inb4 = 0;
        else if (inb4 && txd4 != held4) viol4++;
        st4_d = ts4;
    end

    always @(negedge clk) begin
        if (arm16) armc16++;
        if (da16) dac16++;
        if (ts16 && !st16_d) begin
            log16.push_back(txd16); dal16.push_back(da16);
            held16 = txd16; inb16 = 1; t16 = 3;
        end else if (t16 > 0) begin
            t16--;
            if (t16 == 0) begin busy16 = 1; h16 = 20; end
        end else if (h16 > 0) begin
            h16--;
            if (h16 == 0) begin busy16 = 0; inb16 = 0; end
        end
        if (!rst_n) inb16 = 0;
        else if (inb16 && txd16 != held16) viol16++;
        st16_d = ts16;
    end

    // expected reply bytes for a command accepted in IDLE
    function automatic bq_t model_reply(input logic [7:0] cmd, input logic cd, input int depth, input int w);
        bq_t q;
        int  s = 0;
        if (cmd == 8'h3F) q.push_back({6'b0, cd, 1'b0});
        else if (cmd == 8'h44 && !cd) q.push_back(8'h15);
        else if (cmd == 8'h44) begin
            q.push_back(8'hA5);
            for (int i = 0; i < depth; i++) begin
                q.push_back(w == 0 ? mem4[i] : mem16[i]);
                s += int'(w == 0 ? mem4[i] : mem16[i]);
            end
            q.push_back(8'((256 - s % 256) % 256));
        end
        return q;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_cmd(input int w, input logic [7:0] b, output int lat);
        sel = w; rx_data = b;
        @(negedge clk);
        rx_rdy = 1; lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (lat < 0 && (w == 0 ? ts4 : ts16)) lat = i;
        end
        rx_rdy = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_quiet(input int w, input string nm);
        int q = 0;
        for (int n = 0; n < 6000 && q < 40; n++) begin
            @(negedge clk);
            q = (w == 0 ? (!ts4 && !busy4 && !da4) : (!ts16 && !busy16 && !da16)) ? q + 1 : 0;
        end
        if (q < 40) begin
            checks++; failures++;
            $display("FAIL %s: timeout waiting for idle", nm);
        end
    endtask

    task automatic wait_log(input int w, input int n, input string nm);
        int k = 0;
        while ((w == 0 ? log4.size() : log16.size()) < n && k < 3000) begin
            @(negedge clk); k++;
        end
        if (k >= 3000) begin
            checks++; failures++;
            $display("FAIL %s: timeout waiting for byte %0d", nm, n);
        end
    endtask

    task automatic chk_frame(input string nm, input int w, input int base, input bq_t exp);
        int sz = (w == 0 ? log4.size() : log16.size()) - base;
        chk({nm, " len"}, sz, exp.size());
        if (sz == exp.size())
            for (int i = 0; i < sz; i++)
                chk($sformatf("%s[%0d]", nm, i), int'(w == 0 ? log4[base + i] : log16[base + i]), int'(exp[i]));
    endtask

    initial begin
        vec_t tv[7];
        int   lat, base, a0, d0, ones;
        logic [7:0] c;
        logic cdr;
        tv[0] = '{8'h41, 1'b1, 0, 8'h00, 1};
        tv[1] = '{8'h3F, 1'b1, 1, 8'h02, 0};
        tv[2] = '{8'h3F, 1'b0, 1, 8'h00, 0};
        tv[3] = '{8'h44, 1'b0, 1, 8'h15, 0};
        tv[4] = '{8'h00, 1'b1, 0, 8'h00, 0};
        tv[5] = '{8'h1B, 1'b1, 0, 8'h00, 0};
        tv[6] = '{8'hFF, 1'b0, 0, 8'h00, 0};
        for (int i = 0; i < 4; i++) mem4[i] = 8'(i + 1);
        for (int i = 0; i < 16; i++) mem16[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        chk("reset dut4", int'({txd4, ts4, addr4, arm4, da4}), 0);
        chk("reset dut16", int'({txd16, ts16, addr16, arm16, da16}), 0);
        rst_n = 1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            base = log16.size(); a0 = armc16; d0 = dac16;
            cd16 = tv[i].cd;
            send_cmd(1, tv[i].cmd, lat);
            wait_quiet(1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d bytes", i), log16.size() - base, tv[i].n);
            if (tv[i].n > 0) begin
                chk($sformatf("vec%0d byte", i), log16.size() > base ? int'(log16[base]) : -1, int'(tv[i].b0));
                chk($sformatf("vec%0d latency<=5", i), int'(lat > 0 && lat <= 5), 1);
            end
            chk($sformatf("vec%0d arm cycles", i), armc16 - a0, tv[i].arms);
            chk($sformatf("vec%0d dump_active cycles", i), dac16 - d0, 0);
        end

        base = log4.size(); cd4 = 1;
        send_cmd(0, 8'h44, lat);
        chk("dump4 header latency<=5", int'(lat > 0 && lat <= 5), 1);
        send_cmd(0, 8'h3F, lat);
        send_cmd(0, 8'h3F, lat);
        wait_quiet(0, "dump4");
        chk_frame("dump4", 0, base, model_reply(8'h44, 1'b1, 4, 0));
        ones = 0;
        for (int i = base; i < dal4.size(); i++) ones += int'(dal4[i]);
        chk("dump4 dump_active at byte starts", ones, 6);

        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 16; j++) mem16[j] = 8'($urandom);
            case ($urandom_range(0, 4))
                0: c = 8'h41;
                1: c = 8'h3F;
                2: c = 8'h44;
                default: c = 8'($urandom);
            endcase
            cdr = 1'($urandom);
            if (i < 3) begin c = 8'h44; cdr = 1; end
            base = log16.size(); a0 = armc16; cd16 = cdr;
            send_cmd(1, c, lat);
            cd16 = 0;
            wait_quiet(1, $sformatf("rnd%0d", i));
            chk_frame($sformatf("rnd%0d cmd %0h", i, c), 1, base, model_reply(c, cdr, 16, 1));
            chk($sformatf("rnd%0d arm cycles", i), armc16 - a0, int'(c == 8'h41));
        end

        for (int j = 0; j < 16; j++) mem16[j] = 8'($urandom);
        base = log16.size(); cd16 = 1;
        send_cmd(1, 8'h44, lat);
        wait_log(1, base + 4, "abort");
        send_cmd(1, 8'h1B, lat);
        wait_quiet(1, "abort");
        chk_frame("abort", 1, base, '{8'hA5, mem16[0], mem16[1], mem16[2], 8'h18});
        cd16 = 0; base = log16.size();
        send_cmd(1, 8'h3F, lat);
        wait_quiet(1, "status after abort");
        chk_frame("status after abort", 1, base, '{8'h00});

        for (int j = 0; j < 16; j++) mem16[j] = 8'($urandom);
        base = log16.size(); cd16 = 1;
        send_cmd(1, 8'h44, lat);
        wait_log(1, base + 3, "reset mid-dump");
        chk("mid-dump tx_start before reset", int'(ts16), 1);
        #2 rst_n = 0;
        #1 chk("reset mid-dump outputs", int'({txd16, ts16, addr16, arm16, da16}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        wait_quiet(1, "after reset");
        base = log16.size();
        send_cmd(1, 8'h44, lat);
        chk("restart header latency<=5", int'(lat > 0 && lat <= 5), 1);
        wait_quiet(1, "restart dump");
        chk_frame("restart dump", 1, base, model_reply(8'h44, 1'b1, 16, 1));

        chk("tx_data held dut4", viol4, 0);
        chk("tx_data held dut16", viol16, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
